// File: rtl/j1_io_pkg.sv
// j1_io_pkg: shared constants and helpers for the j1 IO hub.
// Holds default address-bit positions, the status word layout and a clog2
// helper usable in parameter expressions.
package j1_io_pkg;

  // Default one-hot address bits on the j1 IO bus.
  localparam int DEF_UART_BIT   = 12;
  localparam int DEF_STATUS_BIT = 13;
  localparam int DEF_FLAG_BIT   = 14;
  localparam int DEF_CHAN_LSB   = 1;

  // Status word: each channel owns STRIDE bits starting at STRIDE*c.
  localparam int TX_READY_OFS = 0;
  localparam int RX_VALID_OFS = 1;
  localparam int STRIDE       = 2;

  // Ceiling log2; returns 0 for n <= 1 so a single channel needs no index bits.
  function automatic int clog2(input int n);
    int r;
    r = 0;
    for (int i = 0; i < 31; i++) begin
      if ((1 << i) < n) r = i + 1;
    end
    return r;
  endfunction

endpackage

// File: rtl/io_rx_fifo.sv
// io_rx_fifo: byte receive FIFO for one j1 IO channel.
// Ports: clk/reset; push+din write side; pop+dout read side (dout is the
// registered head, valid when !empty); empty/full status; overflow_set pulses
// when a push is dropped because the FIFO is full and not popping.
module io_rx_fifo #(
  parameter int DEPTH = 8
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       push,
  input  logic [7:0] din,
  input  logic       pop,
  output logic [7:0] dout,
  output logic       empty,
  output logic       full,
  output logic       overflow_set
);
  import j1_io_pkg::*;

  localparam int AW = clog2(DEPTH);
  localparam logic [AW:0] CNT_FULL = (AW + 1)'(DEPTH);

  logic [7:0]    mem_q [DEPTH];
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW:0]   cnt_q, cnt_d;
  logic          do_push, do_pop;

  assign empty = (cnt_q == '0);
  assign full  = (cnt_q == CNT_FULL);

  // A pop in the same cycle frees a slot, so a full FIFO still accepts the push.
  assign do_pop       = pop & ~empty;
  assign do_push      = push & (~full | do_pop);
  assign overflow_set = push & full & ~do_pop;

  assign dout = mem_q[rd_ptr_q];

  always_comb begin
    rd_ptr_d = rd_ptr_q;
    wr_ptr_d = wr_ptr_q;
    cnt_d    = cnt_q;
    // Pointers wrap naturally because DEPTH is a power of two.
    if (do_push) wr_ptr_d = wr_ptr_q + AW'(1);
    if (do_pop)  rd_ptr_d = rd_ptr_q + AW'(1);
    case ({do_push, do_pop})
      2'b10:   cnt_d = cnt_q + (AW + 1)'(1);
      2'b01:   cnt_d = cnt_q - (AW + 1)'(1);
      default: cnt_d = cnt_q;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      cnt_q    <= '0;
    end else begin
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
      cnt_q    <= cnt_d;
    end
  end

  // Storage needs no reset: contents are only visible when count is non-zero.
  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q] <= din;
  end

endmodule

// File: rtl/j1_io_hub.sv
// j1_io_hub: j1 IO decode serving NCHAN byte channels.
// Ports: j1 side io_rd/io_wr/mem_addr/dout in, io_din out (read data one cycle
// after the strobe); per-channel rx_valid/rx_data push into RX FIFOs;
// per-channel tx_valid/tx_data/tx_ready one-entry TX holding registers.
module j1_io_hub
  import j1_io_pkg::*;
#(
  parameter int NCHAN      = 2,
  parameter int RXDEPTH    = 8,
  parameter int UART_BIT   = DEF_UART_BIT,
  parameter int STATUS_BIT = DEF_STATUS_BIT,
  parameter int FLAG_BIT   = DEF_FLAG_BIT,
  parameter int CHAN_LSB   = DEF_CHAN_LSB
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 io_rd,
  input  logic                 io_wr,
  input  logic [15:0]          mem_addr,
  input  logic [15:0]          dout,
  output logic [15:0]          io_din,
  input  logic [NCHAN-1:0]     rx_valid,
  input  logic [8*NCHAN-1:0]   rx_data,
  output logic [NCHAN-1:0]     tx_valid,
  output logic [8*NCHAN-1:0]   tx_data,
  input  logic [NCHAN-1:0]     tx_ready
);

  localparam int CW = clog2(NCHAN);
  // Mask extracts the channel index field; zero when NCHAN == 1.
  localparam logic [15:0] CHAN_MASK = 16'((1 << CW) - 1);

  // Registered copies of the j1 request.
  logic        io_rd_q, io_wr_q;
  logic [15:0] io_addr_q, io_addr_d;
  logic [15:0] dout_q;

  logic [NCHAN-1:0]      tx_valid_q, tx_valid_d;
  logic [NCHAN-1:0][7:0] tx_data_q, tx_data_d;
  logic [NCHAN-1:0]      ovf_q, ovf_d;

  logic [15:0]           chan_field;
  logic                  uart_hit, status_hit, flag_hit;
  logic [NCHAN-1:0]      chan_sel;
  logic [NCHAN-1:0]      rx_pop, rx_empty, rx_full, ovf_set, ovf_clr;
  logic [NCHAN-1:0][7:0] rx_head;
  logic [NCHAN-1:0]      tx_wr, tx_fire;
  logic [15:0]           uart_word, status_word, flag_word;

  // The address only loads on a strobe so io_din keeps showing the last
  // selected source between requests.
  always_comb begin
    io_addr_d = io_addr_q;
    if (io_rd | io_wr) io_addr_d = mem_addr;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      io_rd_q   <= 1'b0;
      io_wr_q   <= 1'b0;
      io_addr_q <= '0;
      dout_q    <= '0;
    end else begin
      io_rd_q   <= io_rd;
      io_wr_q   <= io_wr;
      io_addr_q <= io_addr_d;
      dout_q    <= dout;
    end
  end

  assign chan_field = (io_addr_q >> CHAN_LSB) & CHAN_MASK;
  assign uart_hit   = io_addr_q[UART_BIT];
  assign status_hit = io_addr_q[STATUS_BIT];
  assign flag_hit   = io_addr_q[FLAG_BIT];

  for (genvar c = 0; c < NCHAN; c++) begin : g_chan
    // Indices beyond NCHAN-1 match no channel, so such accesses are no-ops.
    assign chan_sel[c] = (chan_field == 16'(c));
    assign rx_pop[c]   = io_rd_q & uart_hit & chan_sel[c];
    assign tx_wr[c]    = io_wr_q & uart_hit & chan_sel[c];

    io_rx_fifo #(
      .DEPTH(RXDEPTH)
    ) u_rx_fifo (
      .clk         (clk),
      .reset       (reset),
      .push        (rx_valid[c]),
      .din         (rx_data[8*c +: 8]),
      .pop         (rx_pop[c]),
      .dout        (rx_head[c]),
      .empty       (rx_empty[c]),
      .full        (rx_full[c]),
      .overflow_set(ovf_set[c])
    );
  end

  assign tx_fire = tx_valid_q & tx_ready;
  assign ovf_clr = {NCHAN{io_wr_q & flag_hit}} & dout_q[NCHAN-1:0];
  // A new overflow in the same cycle as its clear must not be lost.
  assign ovf_d   = ovf_set | (ovf_q & ~ovf_clr);

  always_comb begin
    tx_valid_d = tx_valid_q;
    tx_data_d  = tx_data_q;
    for (int c = 0; c < NCHAN; c++) begin
      // Reload is allowed while the current byte is leaving this cycle.
      if (tx_wr[c] && (!tx_valid_q[c] || tx_fire[c])) begin
        tx_valid_d[c] = 1'b1;
        tx_data_d[c]  = dout_q[7:0];
      end else if (tx_fire[c]) begin
        tx_valid_d[c] = 1'b0;
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      tx_valid_q <= '0;
      tx_data_q  <= '0;
      ovf_q      <= '0;
    end else begin
      tx_valid_q <= tx_valid_d;
      tx_data_q  <= tx_data_d;
      ovf_q      <= ovf_d;
    end
  end

  assign tx_valid = tx_valid_q;
  assign tx_data  = tx_data_q;

  always_comb begin
    uart_word   = '0;
    status_word = '0;
    flag_word   = '0;
    for (int c = 0; c < NCHAN; c++) begin
      if (chan_sel[c] && !rx_empty[c]) uart_word = uart_word | {8'd0, rx_head[c]};
      status_word[STRIDE*c + TX_READY_OFS] = ~tx_valid_q[c];
      status_word[STRIDE*c + RX_VALID_OFS] = ~rx_empty[c];
      flag_word[c] = ovf_q[c];
    end
  end

  // Sources OR together when several select bits are set in one address.
  assign io_din = (uart_hit   ? uart_word   : 16'd0)
                | (status_hit ? status_word : 16'd0)
                | (flag_hit   ? flag_word   : 16'd0);

  logic unused_bits;
  assign unused_bits = ^{dout_q, io_addr_q, rx_full};

endmodule

// File: tb/tb_j1_io_hub.sv
module tb_j1_io_hub;

  logic        clk = 1'b0;
  logic        reset;
  logic        io_rd, io_wr;
  logic [15:0] mem_addr, dout;
  wire  [15:0] io_din;
  logic [1:0]  rx_valid;
  logic [15:0] rx_data;
  wire  [1:0]  tx_valid;
  wire  [15:0] tx_data;
  logic [1:0]  tx_ready;

  int checks = 0;
  int passed = 0;

  // Reference model: per-channel byte queues, TX holding state, overflow bits.
  logic [7:0] mq [2][$];
  logic       m_txv [2];
  logic [7:0] m_txd [2];
  logic       m_ovf [2];

  j1_io_hub dut (
    .clk     (clk),
    .reset   (reset),
    .io_rd   (io_rd),
    .io_wr   (io_wr),
    .mem_addr(mem_addr),
    .dout    (dout),
    .io_din  (io_din),
    .rx_valid(rx_valid),
    .rx_data (rx_data),
    .tx_valid(tx_valid),
    .tx_data (tx_data),
    .tx_ready(tx_ready)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic bus_read(input logic [15:0] a, output logic [15:0] d);
    io_rd = 1'b1; mem_addr = a;
    tick();
    io_rd = 1'b0;
    d = io_din;
    tick();
  endtask

  task automatic bus_write(input logic [15:0] a, input logic [15:0] w);
    io_wr = 1'b1; mem_addr = a; dout = w;
    tick();
    io_wr = 1'b0;
    tick();
  endtask

  task automatic push(input int ch, input logic [7:0] b);
    rx_valid[ch] = 1'b1; rx_data[8*ch +: 8] = b;
    tick();
    rx_valid = '0;
  endtask

  task automatic model_clear();
    for (int c = 0; c < 2; c++) begin
      mq[c].delete(); m_txv[c] = 1'b0; m_txd[c] = 8'h00; m_ovf[c] = 1'b0;
    end
  endtask

  task automatic do_reset();
    reset = 1'b1; io_rd = 0; io_wr = 0; mem_addr = 0; dout = 0;
    rx_valid = 0; rx_data = 0; tx_ready = 0;
    tick(); tick();
    reset = 1'b0;
    model_clear();
    tick();
  endtask

  task automatic test_reset();
    logic [15:0] d;
    do_reset();
    checks++; if (io_din !== 16'h0000) $display("FAIL reset_io_din got %h want 0000", io_din); else passed++;
    checks++; if (tx_valid !== 2'b00) $display("FAIL reset_tx_valid got %b want 00", tx_valid); else passed++;
    checks++; if (tx_data !== 16'h0000) $display("FAIL reset_tx_data got %h want 0000", tx_data); else passed++;
    bus_read(16'h2000, d);
    checks++; if (d !== 16'h0005) $display("FAIL reset_status got %h want 0005", d); else passed++;
  endtask

  task automatic test_rx_read();
    logic [15:0] d;
    logic [15:0] exp_data [3] = '{16'h0041, 16'h0042, 16'h0000};
    logic [15:0] exp_stat [3] = '{16'h000D, 16'h0005, 16'h0005};
    push(1, 8'h41); push(1, 8'h42);
    bus_read(16'h2000, d);
    checks++; if (d !== 16'h000D) $display("FAIL rx_status_pre got %h want 000D", d); else passed++;
    for (int i = 0; i < 3; i++) begin
      bus_read(16'h1002, d);
      checks++; if (d !== exp_data[i]) $display("FAIL rx_read%0d got %h want %h", i, d, exp_data[i]); else passed++;
      bus_read(16'h2000, d);
      checks++; if (d !== exp_stat[i]) $display("FAIL rx_status%0d got %h want %h", i, d, exp_stat[i]); else passed++;
    end
  endtask

  task automatic test_overflow();
    logic [15:0] d;
    for (int i = 0; i < 9; i++) push(0, 8'(i));
    bus_read(16'h4000, d);
    checks++; if (d !== 16'h0001) $display("FAIL ovf_set got %h want 0001", d); else passed++;
    // Clear issued while a new overflow occurs: set must win.
    io_wr = 1'b1; mem_addr = 16'h4000; dout = 16'h0001;
    tick();
    io_wr = 1'b0; rx_valid[0] = 1'b1; rx_data[7:0] = 8'h99;
    tick();
    rx_valid = '0;
    bus_read(16'h4000, d);
    checks++; if (d !== 16'h0001) $display("FAIL ovf_set_wins got %h want 0001", d); else passed++;
    for (int i = 0; i < 8; i++) begin
      bus_read(16'h1000, d);
      checks++; if (d !== 16'(i)) $display("FAIL ovf_drain%0d got %h want %h", i, d, 16'(i)); else passed++;
    end
    bus_write(16'h4000, 16'h0001);
    bus_read(16'h4000, d);
    checks++; if (d !== 16'h0000) $display("FAIL ovf_clear got %h want 0000", d); else passed++;
  endtask

  task automatic test_full_push_pop();
    logic [15:0] d;
    logic [7:0]  exp;
    for (int i = 0; i < 8; i++) push(0, 8'h10 + 8'(i));
    bus_read(16'h2000, d);
    checks++; if (d !== 16'h0007) $display("FAIL fpp_status got %h want 0007", d); else passed++;
    io_rd = 1'b1; mem_addr = 16'h1000;
    tick();
    io_rd = 1'b0; rx_valid[0] = 1'b1; rx_data[7:0] = 8'hAA;
    d = io_din;
    tick();
    rx_valid = '0;
    checks++; if (d !== 16'h0010) $display("FAIL fpp_head got %h want 0010", d); else passed++;
    bus_read(16'h4000, d);
    checks++; if (d !== 16'h0000) $display("FAIL fpp_no_ovf got %h want 0000", d); else passed++;
    for (int i = 0; i < 9; i++) begin
      exp = (i < 7) ? 8'h11 + 8'(i) : ((i == 7) ? 8'hAA : 8'h00);
      bus_read(16'h1000, d);
      checks++; if (d !== {8'h00, exp}) $display("FAIL fpp_drain%0d got %h want %h", i, d, {8'h00, exp}); else passed++;
    end
  endtask

  task automatic test_tx();
    logic [15:0] d;
    tx_ready = 2'b00;
    bus_write(16'h1000, 16'h1055);
    checks++; if (tx_valid !== 2'b01) $display("FAIL tx_load_valid got %b want 01", tx_valid); else passed++;
    checks++; if (tx_data[7:0] !== 8'h55) $display("FAIL tx_load_data got %h want 55", tx_data[7:0]); else passed++;
    bus_read(16'h2000, d);
    checks++; if (d !== 16'h0004) $display("FAIL tx_status got %h want 0004", d); else passed++;
    bus_write(16'h1000, 16'h0066);
    checks++; if (tx_data[7:0] !== 8'h55) $display("FAIL tx_drop got %h want 55", tx_data[7:0]); else passed++;
    io_wr = 1'b1; mem_addr = 16'h1000; dout = 16'h0077;
    tick();
    io_wr = 1'b0; tx_ready = 2'b01;
    tick();
    tx_ready = 2'b00;
    checks++; if (tx_valid !== 2'b01) $display("FAIL tx_b2b_valid got %b want 01", tx_valid); else passed++;
    checks++; if (tx_data[7:0] !== 8'h77) $display("FAIL tx_b2b_data got %h want 77", tx_data[7:0]); else passed++;
    tx_ready = 2'b01;
    tick();
    tx_ready = 2'b00;
    checks++; if (tx_valid !== 2'b00) $display("FAIL tx_drain got %b want 00", tx_valid); else passed++;
  endtask

  task automatic test_reset_mid();
    logic [15:0] d;
    for (int i = 0; i < 8; i++) push(0, 8'hC0 + 8'(i));
    for (int i = 0; i < 9; i++) push(1, 8'(i));
    for (int i = 0; i < 4; i++) bus_read(16'h1000, d);
    bus_write(16'h1002, 16'h00E1);
    io_rd = 1'b1; mem_addr = 16'h1000;
    @(posedge clk); #2;
    reset = 1'b1;
    #1;
    checks++; if (io_din !== 16'h0000) $display("FAIL rstmid_io_din got %h want 0000", io_din); else passed++;
    checks++; if (tx_valid !== 2'b00) $display("FAIL rstmid_tx_valid got %b want 00", tx_valid); else passed++;
    checks++; if (tx_data !== 16'h0000) $display("FAIL rstmid_tx_data got %h want 0000", tx_data); else passed++;
    io_rd = 1'b0;
    tick();
    reset = 1'b0;
    tick();
    bus_read(16'h2000, d);
    checks++; if (d !== 16'h0005) $display("FAIL rstmid_status got %h want 0005", d); else passed++;
    bus_read(16'h4000, d);
    checks++; if (d !== 16'h0000) $display("FAIL rstmid_flags got %h want 0000", d); else passed++;
  endtask

  // Any held byte whose sink is ready leaves at the first edge of the next op.
  task automatic model_edge();
    for (int c = 0; c < 2; c++) if (m_txv[c] && tx_ready[c]) m_txv[c] = 1'b0;
  endtask

  task automatic test_random();
    logic [15:0] d, e;
    int          op, ch;
    logic [7:0]  b;
    do_reset();
    for (int n = 0; n < 400; n++) begin
      op = $urandom_range(0, 6);
      ch = $urandom_range(0, 1);
      b  = 8'($urandom);
      model_edge();
      case (op)
        0, 1: begin
          push(ch, b);
          if (mq[ch].size() < 8) mq[ch].push_back(b); else m_ovf[ch] = 1'b1;
        end
        2: begin
          e = (mq[ch].size() != 0) ? {8'h00, mq[ch][0]} : 16'h0000;
          bus_read(16'h1000 | 16'(ch << 1), d);
          if (mq[ch].size() != 0) void'(mq[ch].pop_front());
          checks++; if (d !== e) $display("FAIL rnd_data op%0d got %h want %h", n, d, e); else passed++;
        end
        3: begin
          e = 16'h0000;
          for (int c = 0; c < 2; c++) begin
            e[2*c]   = ~m_txv[c];
            e[2*c+1] = (mq[c].size() != 0);
          end
          bus_read(16'h2000, d);
          checks++; if (d !== e) $display("FAIL rnd_status op%0d got %h want %h", n, d, e); else passed++;
        end
        4: begin
          bus_write(16'h1000 | 16'(ch << 1), {8'($urandom), b});
          if (!m_txv[ch]) begin m_txv[ch] = 1'b1; m_txd[ch] = b; end
        end
        5: begin
          e = {14'd0, m_ovf[1], m_ovf[0]};
          bus_read(16'h4000, d);
          checks++; if (d !== e) $display("FAIL rnd_flags op%0d got %h want %h", n, d, e); else passed++;
        end
        default: begin
          d = 16'($urandom_range(0, 3));
          bus_write(16'h4000, d);
          for (int c = 0; c < 2; c++) if (d[c]) m_ovf[c] = 1'b0;
        end
      endcase
      e = {m_txd[1], m_txd[0]};
      checks++;
      if (tx_valid !== {m_txv[1], m_txv[0]} || tx_data !== e)
        $display("FAIL rnd_tx op%0d got v=%b d=%h want v=%b d=%h", n, tx_valid, tx_data, {m_txv[1], m_txv[0]}, e);
      else passed++;
      if ($urandom_range(0, 3) == 0) tx_ready = 2'($urandom);
    end
  endtask

  initial begin
    test_reset();
    test_rx_read();
    test_overflow();
    test_full_push_pop();
    test_tx();
    test_reset_mid();
    test_random();
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
